// File: rtl/onehot_decoder_buf.sv
// Registered binary-to-one-hot decoder with a 2-entry output FIFO and valid/ready
// handshakes on both sides; no combinational path from index_i to wire_o.
module onehot_decoder_buf #(
  parameter  int NUM_WIRE = 16,
  localparam int IDX_W    = $clog2(NUM_WIRE)
) (
  input  logic                clk_i,
  input  logic                arst_ni,
  input  logic                clear_i,
  input  logic [IDX_W-1:0]    index_i,
  input  logic                index_valid_i,
  output logic                index_ready_o,
  output logic [NUM_WIRE-1:0] wire_o,
  output logic                wire_valid_o,
  input  logic                wire_ready_i,
  output logic [1:0]          count_o,
  output logic                range_err_o
);

  logic [NUM_WIRE-1:0] mem_q [2];
  logic                rd_ptr_q, wr_ptr_q;
  logic [1:0]          count_q, count_d;
  logic                range_err_q, range_err_d;
  logic                push, pop, in_range;
  logic [NUM_WIRE-1:0] dec;

  assign index_ready_o = (count_q != 2'd2) && !clear_i;
  assign wire_valid_o  = (count_q != 2'd0) && !clear_i;
  assign push          = index_valid_i && index_ready_o;
  assign pop           = wire_valid_o && wire_ready_i;
  assign wire_o        = wire_valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o       = count_q;
  assign range_err_o   = range_err_q;

  // An out-of-range index matches no wire, so the decode is all zeros.
  always_comb begin
    dec = '0;
    for (int i = 0; i < NUM_WIRE; i++) begin
      dec[i] = (index_i == IDX_W'(i));
    end
  end

  assign in_range = |dec;

  always_comb begin
    count_d     = count_q;
    range_err_d = range_err_q;
    if (clear_i) begin
      count_d     = 2'd0;
      range_err_d = 1'b0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
      if (push && !in_range) range_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      range_err_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      range_err_q <= range_err_d;
      if (clear_i) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= dec;
          wr_ptr_q        <= ~wr_ptr_q;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: tb/tb_onehot_decoder_buf.sv
// Bench for onehot_decoder_buf: a 16-wire and a 10-wire instance share stimulus and
// are compared against queue-based reference models, a vector table and directed sequences.
module tb_onehot_decoder_buf;

  logic        clk_i = 1'b0;
  logic        arst_ni, clear_i, index_valid_i, wire_ready_i;
  logic [3:0]  index_i;

  logic        rdy16, wv16, err16;
  logic [1:0]  cnt16;
  logic [15:0] wire16;
  logic        rdy10, wv10, err10;
  logic [1:0]  cnt10;
  logic [9:0]  wire10;

  onehot_decoder_buf #(.NUM_WIRE(16)) dut16 (
    .clk_i(clk_i), .arst_ni(arst_ni), .clear_i(clear_i), .index_i(index_i),
    .index_valid_i(index_valid_i), .index_ready_o(rdy16), .wire_o(wire16),
    .wire_valid_o(wv16), .wire_ready_i(wire_ready_i), .count_o(cnt16), .range_err_o(err16)
  );

  onehot_decoder_buf #(.NUM_WIRE(10)) dut10 (
    .clk_i(clk_i), .arst_ni(arst_ni), .clear_i(clear_i), .index_i(index_i),
    .index_valid_i(index_valid_i), .index_ready_o(rdy10), .wire_o(wire10),
    .wire_valid_o(wv10), .wire_ready_i(wire_ready_i), .count_o(cnt10), .range_err_o(err10)
  );

  always #5 clk_i = ~clk_i;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] q16[$];
  logic [15:0] q10[$];
  logic        merr16, merr10;

  typedef struct {
    logic [3:0]  idx;
    logic        v, r, c;
    logic [15:0] ew;
    logic        evalid, erdy;
    logic [1:0]  ecnt;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int enc(input logic [15:0] w);
    int r = -1;
    for (int i = 0; i < 16; i++) if (w[i]) r = i;
    return r;
  endfunction

  task automatic model_check();
    logic        r, v;
    logic [15:0] w;
    r = (q16.size() != 2) && !clear_i;
    v = (q16.size() != 0) && !clear_i;
    w = v ? q16[0] : 16'h0;
    chk("m16_ready", 32'(rdy16), 32'(r));
    chk("m16_valid", 32'(wv16), 32'(v));
    chk("m16_wire", 32'(wire16), 32'(w));
    chk("m16_count", 32'(cnt16), q16.size());
    chk("m16_err", 32'(err16), 32'(merr16));
    r = (q10.size() != 2) && !clear_i;
    v = (q10.size() != 0) && !clear_i;
    w = v ? q10[0] : 16'h0;
    chk("m10_ready", 32'(rdy10), 32'(r));
    chk("m10_valid", 32'(wv10), 32'(v));
    chk("m10_wire", 32'(wire10), 32'(w));
    chk("m10_count", 32'(cnt10), q10.size());
    chk("m10_err", 32'(err10), 32'(merr10));
  endtask

  task automatic model_reset();
    q16.delete();
    q10.delete();
    merr16 = 1'b0;
    merr10 = 1'b0;
  endtask

  // Called at a rising edge with the inputs that were sampled there.
  task automatic model_update();
    logic pu, po;
    logic [15:0] tmp;
    if (!arst_ni || clear_i) begin
      model_reset();
      return;
    end
    pu = index_valid_i && (q16.size() != 2);
    po = wire_ready_i && (q16.size() != 0);
    if (po) tmp = q16.pop_front();
    if (pu) q16.push_back(16'h1 << index_i);
    pu = index_valid_i && (q10.size() != 2);
    po = wire_ready_i && (q10.size() != 0);
    if (po) tmp = q10.pop_front();
    if (pu) begin
      if (index_i < 4'd10) q10.push_back(16'h1 << index_i);
      else begin
        q10.push_back(16'h0);
        merr10 = 1'b1;
      end
    end
  endtask

  task automatic tick();
    #1;
    model_check();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  initial begin
    tbl[0]  = '{4'd5, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 2'd0};
    tbl[1]  = '{4'd0, 1'b0, 1'b1, 1'b0, 16'h0020, 1'b1, 1'b1, 2'd1};
    tbl[2]  = '{4'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 2'd0};
    tbl[3]  = '{4'd3, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 2'd0};
    tbl[4]  = '{4'd7, 1'b1, 1'b0, 1'b0, 16'h0008, 1'b1, 1'b1, 2'd1};
    tbl[5]  = '{4'd9, 1'b1, 1'b0, 1'b0, 16'h0008, 1'b1, 1'b0, 2'd2};
    tbl[6]  = '{4'd9, 1'b1, 1'b0, 1'b0, 16'h0008, 1'b1, 1'b0, 2'd2};
    tbl[7]  = '{4'd9, 1'b1, 1'b1, 1'b0, 16'h0008, 1'b1, 1'b0, 2'd2};
    tbl[8]  = '{4'd9, 1'b1, 1'b1, 1'b0, 16'h0080, 1'b1, 1'b1, 2'd1};
    tbl[9]  = '{4'd0, 1'b0, 1'b1, 1'b0, 16'h0200, 1'b1, 1'b1, 2'd1};
    tbl[10] = '{4'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 2'd0};
    tbl[11] = '{4'd1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 2'd0};
    tbl[12] = '{4'd2, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b1, 2'd1};
    tbl[13] = '{4'd4, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 2'd2};
    tbl[14] = '{4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 2'd0};

    model_reset();
    arst_ni = 1'b0; clear_i = 1'b0; index_i = 4'd5; index_valid_i = 1'b1; wire_ready_i = 1'b1;
    #2;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_count", 32'(cnt16), 0);
      chk("rst_valid", 32'(wv16), 0);
      chk("rst_wire", 32'(wire16), 0);
      chk("rst_err", 32'(err16), 0);
      chk("rst_ready", 32'(rdy16), 1);
      tick();
    end
    arst_ni = 1'b1; index_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    for (int i = 0; i < 15; i++) begin
      index_i = tbl[i].idx; index_valid_i = tbl[i].v;
      wire_ready_i = tbl[i].r; clear_i = tbl[i].c;
      #1;
      chk($sformatf("tbl%0d_wire", i), 32'(wire16), 32'(tbl[i].ew));
      chk($sformatf("tbl%0d_valid", i), 32'(wv16), 32'(tbl[i].evalid));
      chk($sformatf("tbl%0d_ready", i), 32'(rdy16), 32'(tbl[i].erdy));
      chk($sformatf("tbl%0d_count", i), 32'(cnt16), 32'(tbl[i].ecnt));
      tick();
    end

    for (int i = 0; i <= 16; i++) begin
      index_i = 4'(i); index_valid_i = (i < 16); wire_ready_i = 1'b1; clear_i = 1'b0;
      #1;
      if (i > 0) begin
        chk("stream_valid", 32'(wv16), 1);
        chk("stream_onehot", 32'($onehot(wire16)), 1);
        chk("stream_idx", enc(wire16), i - 1);
      end
      tick();
    end

    clear_i = 1'b1; index_valid_i = 1'b0;
    tick();
    clear_i = 1'b0;
    index_i = 4'd12; index_valid_i = 1'b1;
    tick();
    index_valid_i = 1'b0;
    #1;
    chk("oor_wire", 32'(wire10), 0);
    chk("oor_valid", 32'(wv10), 1);
    chk("oor_err", 32'(err10), 1);
    tick();
    index_i = 4'd3; index_valid_i = 1'b1;
    tick();
    index_valid_i = 1'b0;
    #1;
    chk("oor_next_wire", 32'(wire10), 32'h008);
    chk("oor_sticky", 32'(err10), 1);
    tick();
    wire_ready_i = 1'b0;
    index_i = 4'd4; index_valid_i = 1'b1;
    tick();
    index_i = 4'd5;
    tick();
    index_valid_i = 1'b0;
    #1;
    chk("oor_full", 32'(cnt10), 2);
    chk("oor_sticky2", 32'(err10), 1);
    tick();
    clear_i = 1'b1; index_valid_i = 1'b1; index_i = 4'd6; wire_ready_i = 1'b1;
    #1;
    chk("clr_ready", 32'(rdy10), 0);
    chk("clr_valid", 32'(wv10), 0);
    tick();
    clear_i = 1'b0; index_valid_i = 1'b0;
    #1;
    chk("clr_count", 32'(cnt10), 0);
    chk("clr_err", 32'(err10), 0);
    tick();

    wire_ready_i = 1'b0;
    index_i = 4'd2; index_valid_i = 1'b1;
    tick();
    index_i = 4'd6;
    tick();
    index_valid_i = 1'b0;
    #1;
    chk("ar_full", 32'(cnt16), 2);
    #1;
    arst_ni = 1'b0;
    #1;
    chk("ar_count", 32'(cnt16), 0);
    chk("ar_valid", 32'(wv16), 0);
    chk("ar_wire", 32'(wire16), 0);
    chk("ar_ready", 32'(rdy16), 1);
    chk("ar_count10", 32'(cnt10), 0);
    model_reset();
    @(negedge clk_i);
    arst_ni = 1'b1;
    index_i = 4'd1; index_valid_i = 1'b1;
    @(posedge clk_i);
    model_update();
    #1;
    index_valid_i = 1'b0;
    #1;
    chk("ar_first_wire", 32'(wire16), 32'h0002);
    chk("ar_first_valid", 32'(wv16), 1);
    wire_ready_i = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 600; i++) begin
      index_i       = 4'($urandom_range(15));
      index_valid_i = 1'($urandom_range(1));
      wire_ready_i  = ($urandom_range(3) != 0);
      clear_i       = ($urandom_range(31) == 0);
      tick();
    end
    clear_i = 1'b0; index_valid_i = 1'b0; wire_ready_i = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
